cmd_dispatch: RTL and testbench
===============================

Name: cmd_dispatch

Overview:
Parametrised host-command parser between the rx FIFO read side and the functional blocks. It consumes a command byte plus a fixed-length payload and acts on it. Actions are writing or reading an internal register file, pulsing trigger strobes, or handing a 16-bit word to an auxiliary serial-config block. It generalises the fixed 3-register / 2-byte-payload controller: configurable register count and width, register read-back through a response handshake, payload timeout, and an error counter.

Parameters:
NUM_REGS, 4, number of registers in the file (1..256).
REG_W, 8, register width in bits (1..16); write payload is ceil(REG_W/8) bytes, MSB first.
NUM_TRIG, 4, number of trigger strobes (1..16).
TRIG_LEN, 2, trigger pulse length in clk cycles (>=1).
TIMEOUT, 1000000, max clk cycles allowed between consecutive payload bytes.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
rx_empty  in  1  rx FIFO empty
rx_hold  in  1  host interface busy; no byte consumed while high
rx_rdata  in  8  FIFO head byte (show-ahead, valid while rx_empty=0)
rx_rinc  out  1  one-cycle pop; rx_rdata is captured in the same cycle
regs  out  NUM_REGS*REG_W  flattened register file; reg k at [k*REG_W +: REG_W]
trig  out  NUM_TRIG  trigger strobes
aux_data  out  16  word for the auxiliary block
aux_toggle  out  1  aux start, high 2 cycles
aux_busy  in  1  aux block busy
resp_data  out  16  read-back value, zero-extended
resp_valid  out  1  response pending
resp_accept  in  1  response consumed
err_count  out  8  saturating error counter
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE; regs, aux_data, resp_data and err_count cleared to 0.
  - trig, aux_toggle, resp_valid, rx_rinc are 0.
  - Reset mid-command abandons it; bytes already popped are lost.
- Byte fetch: rx_rinc=1 only in a fetch state with rx_empty=0 and rx_hold=0. Exactly one byte is popped per rinc cycle.
- Command codes:
  - 0x00: NOP.
  - 0x01: CLEAR. All regs set to 0; err_count unchanged.
  - 0x10+k: TRIG k. Valid only for k<NUM_TRIG; larger k is an error.
  - 0x20: WRITE. Payload is addr, then data bytes.
  - 0x21: READ. Payload is addr.
  - 0x30: AUX. Payload is msb, lsb.
  - Any other code is an error: err_count+1, return to IDLE.
- States:
  - IDLE: pop cmd byte -> DECODE.
  - DECODE (1 cycle): set remaining-byte count (WRITE 1+ceil(REG_W/8), READ 1, AUX 2, others 0), clear timeout counter -> PAYLOAD, or straight to the action state.
  - PAYLOAD: pop bytes into a shift register. Timeout counter resets on each pop. If the counter reaches TIMEOUT: err_count+1 -> IDLE. Last byte popped -> action state.
  - EXEC_WR (1 cycle): if addr<NUM_REGS, reg[addr] <= low REG_W bits of assembled data (excess high bits dropped); else err_count+1. -> IDLE.
  - EXEC_RD (1 cycle): resp_data = reg[addr] zero-extended, or 0xFFFF with err_count+1 if addr>=NUM_REGS. Sets resp_valid -> RESP.
  - RESP: hold until resp_accept=1 with resp_valid=1. resp_valid drops the next cycle -> IDLE. No bytes consumed meanwhile.
  - AUX_WAIT: wait for aux_busy=0, then load aux_data={msb,lsb} -> AUX1 -> AUX2 (aux_toggle=1 in both) -> IDLE.
  - TRIG: trig[k]=1 for exactly TRIG_LEN cycles -> IDLE.
- Latency:
  - WRITE: regs update on the cycle after the last payload pop.
  - READ: resp_valid rises on the cycle after the addr pop.
- err_count saturates at 0xFF.
- Outputs are registered, except rx_rinc, which may be combinational from state and inputs.

Test Plan:
- Reset, then push 0x20,0x02,0xA5 (REG_W=8) -> regs[2]=0xA5 one cycle after the third pop; other regs 0; err_count=0.
- Push 0x21,0x02; hold resp_accept=0 for 50 cycles while pushing 0x00 -> resp_data=0x00A5 and resp_valid high throughout; NOP not popped until accept, then popped.
- Push 0x11 (NUM_TRIG=4, TRIG_LEN=2) -> trig=0b0010 for exactly 2 cycles. Push 0x17 -> trig stays 0, err_count=1.
- Push 0x30,0x12,0x34 with aux_busy=1 for 20 cycles -> no aux_toggle while busy; then aux_data=0x1234 and aux_toggle high for 2 cycles.
- TIMEOUT=100: push 0x20,0x01 only -> after 100 cycles without a byte, err_count+1, busy=0. Then 0x21,0x05 with NUM_REGS=4 -> resp_data=0xFFFF, err_count+1.
- rx_hold=1 with data present -> no rx_rinc. Assert rst between payload bytes -> IDLE, all regs 0, remaining byte treated as a new command.

Source files
------------

// File: rtl/cmd_dispatch.sv
// cmd_dispatch: host command parser that pops command/payload bytes from the rx FIFO
// and drives a register file, trigger strobes, an aux config word and read-back responses.
module cmd_dispatch #(
    parameter int NUM_REGS = 4,
    parameter int REG_W    = 8,
    parameter int NUM_TRIG = 4,
    parameter int TRIG_LEN = 2,
    parameter int TIMEOUT  = 1000000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rx_empty,
    input  logic                      rx_hold,
    input  logic [7:0]                rx_rdata,
    output logic                      rx_rinc,
    output logic [NUM_REGS*REG_W-1:0] regs,
    output logic [NUM_TRIG-1:0]       trig,
    output logic [15:0]               aux_data,
    output logic                      aux_toggle,
    input  logic                      aux_busy,
    output logic [15:0]               resp_data,
    output logic                      resp_valid,
    input  logic                      resp_accept,
    output logic [7:0]                err_count,
    output logic                      busy
);
    localparam int NB   = (REG_W + 7) / 8;
    localparam int SW   = 8 * (NB + 1);
    localparam int TMAX = TIMEOUT > TRIG_LEN ? TIMEOUT : TRIG_LEN;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [3:0] {
        IDLE, DECODE, PAYLOAD, EXEC_WR, EXEC_RD, RESP, AUX_WAIT, AUX1, AUX2, TRIG
    } state_t;

    state_t state, state_next;
    logic [7:0] cmd;
    logic [SW-1:0] shift;
    logic [1:0] pcnt;
    logic [TW-1:0] tcnt;
    logic err, addr_ok, trig_ok;
    logic [7:0] addr;
    logic [REG_W-1:0] rd_val;

    assign rx_rinc = (state == IDLE || state == PAYLOAD) && !rx_empty && !rx_hold;
    // READ (0x21) carries only the addr byte; WRITE keeps addr above the data bytes
    assign addr    = cmd[0] ? shift[7:0] : shift[8*NB +: 8];
    assign addr_ok = {1'b0, addr} < 9'(NUM_REGS);
    assign trig_ok = cmd[7:4] == 4'h1 && {1'b0, cmd[3:0]} < 5'(NUM_TRIG);

    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (addr == 8'(i)) rd_val = regs[i*REG_W +: REG_W];
    end

    always_comb begin
        state_next = state;
        err = 1'b0;
        case (state)
            IDLE:     if (rx_rinc) state_next = DECODE;
            DECODE: begin
                state_next = IDLE;
                if (cmd == 8'h20 || cmd == 8'h21 || cmd == 8'h30) state_next = PAYLOAD;
                else if (trig_ok) state_next = TRIG;
                else if (cmd > 8'h01) err = 1'b1;
            end
            PAYLOAD: begin
                if (rx_rinc && pcnt == 2'd1)
                    state_next = cmd == 8'h20 ? EXEC_WR : cmd == 8'h21 ? EXEC_RD : AUX_WAIT;
                else if (!rx_rinc && tcnt == TW'(TIMEOUT - 1)) begin
                    state_next = IDLE;
                    err = 1'b1;
                end
            end
            EXEC_WR: begin
                state_next = IDLE;
                err = !addr_ok;
            end
            EXEC_RD: begin
                state_next = RESP;
                err = !addr_ok;
            end
            RESP:     if (resp_accept && resp_valid) state_next = IDLE;
            AUX_WAIT: if (!aux_busy) state_next = AUX1;
            AUX1:     state_next = AUX2;
            AUX2:     state_next = IDLE;
            TRIG:     if (tcnt == TW'(TRIG_LEN - 1)) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_next;
    end

    // strobes are registered from the next state so they line up with the state itself
    always_ff @(posedge clk) begin
        if (rst) begin
            regs       <= '0;
            trig       <= '0;
            aux_data   <= '0;
            aux_toggle <= 1'b0;
            resp_data  <= '0;
            resp_valid <= 1'b0;
            err_count  <= '0;
            busy       <= 1'b0;
            cmd        <= '0;
            shift      <= '0;
            pcnt       <= '0;
            tcnt       <= '0;
        end else begin
            trig       <= state_next == TRIG ? NUM_TRIG'(1) << cmd[3:0] : '0;
            aux_toggle <= state_next == AUX1 || state_next == AUX2;
            resp_valid <= state_next == RESP;
            busy       <= state_next != IDLE;
            if (err && err_count != 8'hFF) err_count <= err_count + 8'd1;
            if (rx_rinc && state == IDLE) cmd <= rx_rdata;
            if (rx_rinc && state == PAYLOAD) begin
                shift <= {shift[SW-9:0], rx_rdata};
                pcnt  <= pcnt - 2'd1;
            end
            if (state == DECODE || rx_rinc) tcnt <= '0;
            else if (state == PAYLOAD || state == TRIG) tcnt <= tcnt + TW'(1);
            if (state == DECODE) pcnt <= cmd == 8'h20 ? 2'(1 + NB) : cmd == 8'h30 ? 2'd2 : 2'd1;
            if (state == DECODE && cmd == 8'h01) regs <= '0;
            if (state == EXEC_WR)
                for (int i = 0; i < NUM_REGS; i++)
                    if (addr == 8'(i)) regs[i*REG_W +: REG_W] <= shift[REG_W-1:0];
            if (state == EXEC_RD) resp_data <= addr_ok ? 16'(rd_val) : 16'hFFFF;
            if (state == AUX_WAIT && !aux_busy) aux_data <= shift[15:0];
        end
    end
endmodule

// File: tb/tb_cmd_dispatch.sv
// tb_cmd_dispatch: directed self-checking bench for cmd_dispatch (defaults, TIMEOUT=100).
module tb_cmd_dispatch;
    logic clk = 1'b0;
    logic rst, rx_empty, rx_hold, rx_rinc, aux_toggle, aux_busy;
    logic resp_valid, resp_accept, busy;
    logic [7:0] rx_rdata, err_count;
    logic [31:0] regs;
    logic [3:0] trig;
    logic [15:0] aux_data, resp_data;
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    cmd_dispatch #(.NUM_REGS(4), .REG_W(8), .NUM_TRIG(4), .TRIG_LEN(2), .TIMEOUT(100)) dut (
        .clk(clk), .rst(rst), .rx_empty(rx_empty), .rx_hold(rx_hold), .rx_rdata(rx_rdata),
        .rx_rinc(rx_rinc), .regs(regs), .trig(trig), .aux_data(aux_data),
        .aux_toggle(aux_toggle), .aux_busy(aux_busy), .resp_data(resp_data),
        .resp_valid(resp_valid), .resp_accept(resp_accept), .err_count(err_count), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // present a byte and wait (bounded) for it to be popped; returns just after the pop edge
    task automatic push(input logic [7:0] b);
        int n = 0;
        rx_rdata = b;
        rx_empty = 1'b0;
        @(negedge clk);
        while (!rx_rinc && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("pop", 32'(rx_rinc), 32'd1);
        @(posedge clk);
        #1 rx_empty = 1'b1;
    endtask

    initial begin
        rst = 1'b1; rx_empty = 1'b1; rx_hold = 1'b0; rx_rdata = '0;
        aux_busy = 1'b0; resp_accept = 1'b0;
        tick(2);
        rst = 1'b0;
        check("rst_regs", regs, 32'h0);
        check("rst_err", 32'(err_count), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_rv", 32'(resp_valid), 32'h0);
        check("rst_trig", 32'(trig), 32'h0);
        check("rst_aux", 32'(aux_toggle), 32'h0);
        check("rst_rinc", 32'(rx_rinc), 32'h0);

        push(8'h20); push(8'h02); push(8'hA5);
        check("wr_pre", regs, 32'h0);
        tick();
        check("wr_regs", regs, 32'h00A5_0000);
        check("wr_err", 32'(err_count), 32'h0);

        push(8'h21); push(8'h02);
        check("rd_pre", 32'(resp_valid), 32'h0);
        tick();
        check("rd_valid", 32'(resp_valid), 32'h1);
        check("rd_data", 32'(resp_data), 32'h00A5);
        rx_rdata = 8'h00;
        rx_empty = 1'b0;
        repeat (50) begin
            @(negedge clk);
            check("rd_hold_rinc", 32'(rx_rinc), 32'h0);
            check("rd_hold_valid", 32'(resp_valid), 32'h1);
        end
        check("rd_hold_data", 32'(resp_data), 32'h00A5);
        @(negedge clk) resp_accept = 1'b1;
        tick();
        resp_accept = 1'b0;
        check("rd_drop", 32'(resp_valid), 32'h0);
        @(negedge clk);
        check("nop_pop", 32'(rx_rinc), 32'h1);
        tick();
        rx_empty = 1'b1;
        tick(3);
        check("nop_idle", 32'(busy), 32'h0);

        push(8'h11);
        check("trig_c0", 32'(trig), 32'h0);
        tick(); check("trig_c1", 32'(trig), 32'h2);
        tick(); check("trig_c2", 32'(trig), 32'h2);
        tick(); check("trig_c3", 32'(trig), 32'h0);
        push(8'h17);
        repeat (4) begin
            tick();
            check("trig_bad", 32'(trig), 32'h0);
        end
        check("trig_err", 32'(err_count), 32'h1);

        aux_busy = 1'b1;
        push(8'h30); push(8'h12); push(8'h34);
        repeat (20) begin
            tick();
            check("aux_wait", 32'(aux_toggle), 32'h0);
        end
        aux_busy = 1'b0;
        tick();
        check("aux_t1", 32'(aux_toggle), 32'h1);
        check("aux_data", 32'(aux_data), 32'h1234);
        tick(); check("aux_t2", 32'(aux_toggle), 32'h1);
        tick(); check("aux_t3", 32'(aux_toggle), 32'h0);
        check("aux_idle", 32'(busy), 32'h0);

        push(8'h20); push(8'h01);
        tick(95);
        check("to_busy", 32'(busy), 32'h1);
        check("to_err_pre", 32'(err_count), 32'h1);
        tick(10);
        check("to_idle", 32'(busy), 32'h0);
        check("to_err", 32'(err_count), 32'h2);
        check("to_regs", regs, 32'h00A5_0000);

        push(8'h21); push(8'h05);
        tick();
        check("rdbad_valid", 32'(resp_valid), 32'h1);
        check("rdbad_data", 32'(resp_data), 32'hFFFF);
        check("rdbad_err", 32'(err_count), 32'h3);
        resp_accept = 1'b1;
        tick();
        resp_accept = 1'b0;
        check("rdbad_drop", 32'(resp_valid), 32'h0);

        push(8'h01);
        tick();
        check("clr_regs", regs, 32'h0);
        check("clr_err", 32'(err_count), 32'h3);

        rx_hold = 1'b1;
        rx_rdata = 8'h20;
        rx_empty = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("hold_rinc", 32'(rx_rinc), 32'h0);
        end
        rx_empty = 1'b1;
        rx_hold = 1'b0;
        tick();

        push(8'h20); push(8'h01); push(8'h3C);
        tick();
        check("wr1_regs", regs, 32'h0000_3C00);
        push(8'h20); push(8'h03);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_regs", regs, 32'h0);
        check("mid_rst_err", 32'(err_count), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        push(8'h55);
        tick(2);
        check("newcmd_err", 32'(err_count), 32'h1);
        check("newcmd_busy", 32'(busy), 32'h0);
        check("newcmd_regs", regs, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
